interrupt_ack_sequencer: RTL and testbench
==========================================

Name: interrupt_ack_sequencer

Overview:
- Consumer side of the priority resolver in the 8259-compatible PIC.
- Takes the resolver's one-hot `interrupt` word and drives the INT pin.
- Runs the 8086-mode two-pulse INTA handshake, owns the In-Service Register (ISR) and the rotation pointer, and executes EOI / set-priority commands.
- Its `in_service_register` and `priority_rotate` outputs feed back into the priority resolver.

Parameters:
- SPURIOUS_LEVEL, 3'd7, IR level reported when the request vanishes before the first INTA.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- interrupt  in  8  one-hot resolved request from the priority resolver (zero = none)
- inta_n  in  1  INTA strobe, active-low, already synchronised to clk
- vector_base  in  5  ICW2 bits T7..T3
- auto_eoi  in  1  ICW4 AEOI bit
- auto_rotate  in  1  rotate-in-AEOI mode (OCW2 R=1, SL=0, EOI=0 previously issued)
- eoi_valid  in  1  one-cycle OCW2 EOI command strobe
- eoi_specific  in  1  1 = specific EOI (uses eoi_level); 0 = non-specific
- eoi_rotate  in  1  rotate on this EOI
- eoi_level  in  3  level for specific EOI
- set_priority_valid  in  1  one-cycle OCW2 set-priority strobe (uses eoi_level)
- int_out  out  1  INT pin to CPU, active-high
- in_service_register  out  8  ISR, bit n = IR n in service
- priority_rotate  out  3  index of the highest-priority IR
- clear_request  out  8  one-cycle pulse clearing the IRR bit of the acknowledged level
- data_out  out  8  vector byte
- data_out_en  out  1  data bus drive enable

Behaviour:
- Reset (async, rst_n=0): int_out=0, ISR=0, priority_rotate=0, clear_request=0, data_out=0, data_out_en=0, FSM=IDLE.
  - Reset mid-handshake aborts with no ISR change.
- inta_n is registered once to detect edges. "Fall" = previous 1 and current 0; "rise" = previous 0 and current 1.
- FSM states: IDLE, INT_PENDING, ACK1, ACK2.
- IDLE
  - interrupt != 0 → int_out=1 on the next edge, go to INT_PENDING.
  - inta_n falls while in IDLE: ignore it; data_out_en stays 0.
- INT_PENDING (int_out=1)
  - interrupt returns to 0 before an INTA fall: stay here; int_out stays 1 (matches the 8259 latched-INT behaviour).
  - inta_n falls:
    - Latch level L = encode(interrupt). If interrupt==0, L=SPURIOUS_LEVEL and this is a spurious cycle.
    - Non-spurious: set ISR[L]=1 and pulse clear_request[L] for one cycle.
    - int_out=0; go to ACK1.
- ACK1
  - Wait for inta_n rise, then the next fall.
  - On that fall: data_out={vector_base,L}, data_out_en=1, go to ACK2.
- ACK2
  - data_out_en stays 1 while inta_n=0.
  - On rise: data_out_en=0.
  - If auto_eoi and not spurious: clear ISR[L] in the same cycle. If auto_rotate is also set, priority_rotate=L+1 (mod 8).
  - Return to IDLE. int_out may rise on the following cycle if interrupt != 0.
- Specific EOI (eoi_valid, eoi_specific=1)
  - Clear ISR[eoi_level]; a no-op if that bit is already 0.
  - If eoi_rotate: priority_rotate=eoi_level+1 (mod 8).
- Non-specific EOI (eoi_valid, eoi_specific=0)
  - Find the highest-priority set ISR bit, scanning from priority_rotate upward with wrap 7→0, and clear it.
  - If eoi_rotate: priority_rotate = that level + 1.
  - ISR==0 → no change at all, including the rotation pointer.
- set_priority_valid: priority_rotate=eoi_level+1 (mod 8); ISR unchanged.
- Simultaneous events:
  - An EOI is evaluated against the ISR value before this cycle's INTA set. Clear and set are then merged; a set of the same bit wins.
  - eoi_valid and set_priority_valid together: set_priority wins for priority_rotate; the EOI's ISR clear still happens.
  - AEOI clear and an explicit EOI in the same cycle: both clears apply. The AEOI rotate wins over the EOI rotate.
- Widths: all level arithmetic is 3-bit and wraps naturally.

Decomposition:
- Shared pic package:
  - FSM state enum.
  - SPURIOUS_LEVEL default.
  - Function onehot_to_level (8→3).
  - Function rotate_mask helpers, reused by the priority resolver.
- Sub-module `isr_highest_level`: combinational scan of the ISR from priority_rotate with wrap. Outputs level[2:0] and found.

Test Plan:
- interrupt=8'h08, vector_base=5'h11, auto_eoi=0, two INTA pulses:
  - int_out rises.
  - After the first fall: ISR=8'h08 and clear_request=8'h08 for 1 cycle.
  - During the second pulse: data_out=8'h8B with data_out_en=1.
  - ISR holds 8'h08 afterwards.
- Spurious: interrupt=8'h04 raises INT, then drops to 0 before INTA:
  - data_out={vector_base,3'd7}.
  - ISR stays 0; clear_request stays 0.
- ISR=8'h24, priority_rotate=3'd3, non-specific EOI with rotate → ISR=8'h04, priority_rotate=3'd6.
- auto_eoi=1, auto_rotate=1, interrupt=8'h80 acknowledged:
  - ISR returns to 0 on the second INTA rise.
  - priority_rotate=3'd0 (wrap).
- eoi_valid specific level 2 in the same cycle that the first INTA sets ISR[2] → ISR[2]=1 (set wins).
- rst_n pulsed low while in ACK1: all outputs are 0 immediately (asynchronously); the next INTA fall in IDLE is ignored.

Source files
------------

// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared definitions for the 8259-style interrupt acknowledge path: FSM states,
// the spurious level default and level/mask helpers also used by the priority resolver.
package interrupt_ack_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIntPending,
        StAck1,
        StAck2
    } ack_state_e;

    localparam logic [2:0] SPURIOUS_LEVEL_DEFAULT = 3'd7;

    // Lowest set bit wins, so a non-one-hot word still yields a deterministic level.
    function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
        logic [2:0] level;
        level = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (onehot[i]) level = 3'(i);
        end
        return level;
    endfunction

    function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
        return 8'd1 << level;
    endfunction

    // Bit j of the result is vec[(j + amount) mod 8].
    function automatic logic [7:0] rotate_right(input logic [7:0] vec, input logic [2:0] amount);
        logic [15:0] dbl;
        dbl = {vec, vec} >> amount;
        return dbl[7:0];
    endfunction

    // Bit j of the result is vec[(j - amount) mod 8].
    function automatic logic [7:0] rotate_left(input logic [7:0] vec, input logic [2:0] amount);
        logic [15:0] dbl;
        dbl = {vec, vec} << amount;
        return dbl[15:8];
    endfunction

endpackage

// File: rtl/isr_highest_level.sv
// Finds the highest-priority in-service level, scanning upward from the rotation
// pointer with wrap 7 -> 0.
module isr_highest_level
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic [7:0] isr,
    input  logic [2:0] priority_rotate,
    output logic [2:0] level,
    output logic       found
);

    logic [7:0] rotated;
    logic [2:0] offset;

    always_comb begin
        rotated = rotate_right(isr, priority_rotate);
        offset  = onehot_to_level(rotated);
        found   = |isr;
        level   = priority_rotate + offset;
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Drives INT, runs the two-pulse INTA handshake, and owns the ISR and rotation
// pointer including EOI and set-priority commands.
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = SPURIOUS_LEVEL_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       auto_rotate,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    input  logic       set_priority_valid,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_request,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    ack_state_e state_q, state_d;
    logic       inta_q;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic       int_out_q, int_out_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] rot_q, rot_d;
    logic [7:0] clear_request_q, clear_request_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_out_en_q, data_out_en_d;

    logic       inta_fall, inta_rise;
    logic [7:0] isr_set, aeoi_clr, eoi_clr;
    logic       aeoi_rot, eoi_rot_en;
    logic [2:0] eoi_rot_level;
    logic [2:0] scan_level;
    logic       scan_found;

    isr_highest_level u_scan (
        .isr             (isr_q),
        .priority_rotate (rot_q),
        .level           (scan_level),
        .found           (scan_found)
    );

    always_comb begin
        inta_fall       = inta_q & ~inta_n;
        inta_rise       = ~inta_q & inta_n;
        state_d         = state_q;
        level_d         = level_q;
        spurious_d      = spurious_q;
        int_out_d       = int_out_q;
        clear_request_d = '0;
        data_out_d      = data_out_q;
        data_out_en_d   = data_out_en_q;
        isr_set         = '0;
        aeoi_clr        = '0;
        aeoi_rot        = 1'b0;

        case (state_q)
            StIdle: begin
                if (interrupt != '0) begin
                    int_out_d = 1'b1;
                    state_d   = StIntPending;
                end
            end
            StIntPending: begin
                if (inta_fall) begin
                    if (interrupt == '0) begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end else begin
                        level_d         = onehot_to_level(interrupt);
                        spurious_d      = 1'b0;
                        isr_set         = level_to_onehot(onehot_to_level(interrupt));
                        clear_request_d = isr_set;
                    end
                    int_out_d = 1'b0;
                    state_d   = StAck1;
                end
            end
            // Any fall seen here was necessarily preceded by a rise.
            StAck1: begin
                if (inta_fall) begin
                    data_out_d    = {vector_base, level_q};
                    data_out_en_d = 1'b1;
                    state_d       = StAck2;
                end
            end
            StAck2: begin
                if (inta_rise) begin
                    data_out_en_d = 1'b0;
                    if (auto_eoi && !spurious_q) begin
                        aeoi_clr = level_to_onehot(level_q);
                        aeoi_rot = auto_rotate;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // EOI always looks at the ISR as it stood before this cycle's INTA set.
        eoi_clr       = '0;
        eoi_rot_en    = 1'b0;
        eoi_rot_level = eoi_level;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_clr    = level_to_onehot(eoi_level);
                eoi_rot_en = eoi_rotate;
            end else if (scan_found) begin
                eoi_clr       = level_to_onehot(scan_level);
                eoi_rot_en    = eoi_rotate;
                eoi_rot_level = scan_level;
            end
        end

        isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;

        // Later assignments take precedence: set-priority over AEOI over EOI.
        rot_d = rot_q;
        if (eoi_rot_en) rot_d = eoi_rot_level + 3'd1;
        if (aeoi_rot) rot_d = level_q + 3'd1;
        if (set_priority_valid) rot_d = eoi_level + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            inta_q          <= 1'b1;
            level_q         <= '0;
            spurious_q      <= 1'b0;
            int_out_q       <= 1'b0;
            isr_q           <= '0;
            rot_q           <= '0;
            clear_request_q <= '0;
            data_out_q      <= '0;
            data_out_en_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            inta_q          <= inta_n;
            level_q         <= level_d;
            spurious_q      <= spurious_d;
            int_out_q       <= int_out_d;
            isr_q           <= isr_d;
            rot_q           <= rot_d;
            clear_request_q <= clear_request_d;
            data_out_q      <= data_out_d;
            data_out_en_q   <= data_out_en_d;
        end
    end

    assign int_out             = int_out_q;
    assign in_service_register = isr_q;
    assign priority_rotate     = rot_q;
    assign clear_request       = clear_request_q;
    assign data_out            = data_out_q;
    assign data_out_en         = data_out_en_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Randomised bench for interrupt_ack_sequencer against a behavioural model, plus
// directed scenarios with hand-computed expectations.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] interrupt = '0;
    logic       inta_n = 1'b1;
    logic [4:0] vector_base = '0;
    logic       auto_eoi = 1'b0;
    logic       auto_rotate = 1'b0;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic       eoi_rotate = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       set_priority_valid = 1'b0;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [2:0] priority_rotate;
    logic [7:0] clear_request;
    logic [7:0] data_out;
    logic       data_out_en;

    interrupt_ack_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .interrupt           (interrupt),
        .inta_n              (inta_n),
        .vector_base         (vector_base),
        .auto_eoi            (auto_eoi),
        .auto_rotate         (auto_rotate),
        .eoi_valid           (eoi_valid),
        .eoi_specific        (eoi_specific),
        .eoi_rotate          (eoi_rotate),
        .eoi_level           (eoi_level),
        .set_priority_valid  (set_priority_valid),
        .int_out             (int_out),
        .in_service_register (in_service_register),
        .priority_rotate     (priority_rotate),
        .clear_request       (clear_request),
        .data_out            (data_out),
        .data_out_en         (data_out_en)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    logic       m_int;
    logic [7:0] m_isr;
    int         m_rot;
    logic [7:0] m_clr;
    logic [7:0] m_dout;
    logic       m_den;
    bit         m_busy;
    int         m_falls;
    int         m_level;
    bit         m_spur;
    logic       m_prev_inta;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_int = 0; m_isr = '0; m_rot = 0; m_clr = '0; m_dout = '0; m_den = 0;
        m_busy = 0; m_falls = 0; m_level = 0; m_spur = 0; m_prev_inta = 1'b1;
    endtask

    // Advances the model by one clock using the inputs presented at this edge.
    task automatic model_step();
        logic       fall, rise;
        logic [7:0] clr, set_m;
        int         nrot, lvl;
        fall = m_prev_inta && !inta_n;
        rise = !m_prev_inta && inta_n;
        clr = '0; set_m = '0; nrot = m_rot; m_clr = '0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                clr = clr | (8'd1 << eoi_level);
                if (eoi_rotate) nrot = (int'(eoi_level) + 1) % 8;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    lvl = (m_rot + k) % 8;
                    if (m_isr[lvl]) begin
                        clr = clr | (8'd1 << lvl);
                        if (eoi_rotate) nrot = (lvl + 1) % 8;
                        break;
                    end
                end
            end
        end
        if (!m_busy) begin
            if (interrupt != 0) begin
                m_busy = 1; m_falls = 0; m_int = 1;
            end
        end else if (m_falls == 0) begin
            if (fall) begin
                m_spur = (interrupt == 0);
                m_level = 7;
                for (int k = 7; k >= 0; k--) if (interrupt[k]) m_level = k;
                if (!m_spur) begin
                    set_m = 8'd1 << m_level;
                    m_clr = set_m;
                end
                m_int = 0; m_falls = 1;
            end
        end else if (m_falls == 1) begin
            if (fall) begin
                m_dout = {vector_base, 3'(m_level)};
                m_den = 1; m_falls = 2;
            end
        end else if (rise) begin
            m_den = 0; m_busy = 0;
            if (auto_eoi && !m_spur) begin
                clr = clr | (8'd1 << m_level);
                if (auto_rotate) nrot = (m_level + 1) % 8;
            end
        end
        if (set_priority_valid) nrot = (int'(eoi_level) + 1) % 8;
        m_isr = (m_isr & ~clr) | set_m;
        m_rot = nrot;
        m_prev_inta = inta_n;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("int_out", {7'd0, int_out}, {7'd0, m_int});
            check("isr", in_service_register, m_isr);
            check("priority_rotate", {5'd0, priority_rotate}, 8'(m_rot));
            check("clear_request", clear_request, m_clr);
            check("data_out", data_out, m_dout);
            check("data_out_en", {7'd0, data_out_en}, {7'd0, m_den});
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic ack(input logic [7:0] irq);
        interrupt = irq;
        tick();
        inta_n = 1'b0;
        tick();
        interrupt = '0;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
    endtask

    initial begin
        model_reset();
        do_reset();
        chk_on = 1'b1;

        // Normal acknowledge of IR3
        vector_base = 5'h11;
        interrupt = 8'h08;
        tick(); sample();
        check("t1_int_rise", {7'd0, int_out}, 8'h01);
        inta_n = 1'b0;
        tick(); sample();
        check("t1_isr_set", in_service_register, 8'h08);
        check("t1_clear_req", clear_request, 8'h08);
        interrupt = '0;
        tick(); sample();
        check("t1_clear_req_pulse", clear_request, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick(); sample();
        check("t1_vector", data_out, 8'h8B);
        check("t1_den", {7'd0, data_out_en}, 8'h01);
        inta_n = 1'b1; tick(); sample();
        check("t1_den_off", {7'd0, data_out_en}, 8'h00);
        check("t1_isr_hold", in_service_register, 8'h08);

        // Spurious cycle
        do_reset();
        interrupt = 8'h04;
        tick(); sample();
        check("t2_int_rise", {7'd0, int_out}, 8'h01);
        interrupt = '0;
        tick(); tick(); sample();
        check("t2_int_latched", {7'd0, int_out}, 8'h01);
        inta_n = 1'b0; tick(); sample();
        check("t2_isr", in_service_register, 8'h00);
        check("t2_clear_req", clear_request, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick(); sample();
        check("t2_vector", data_out, 8'h8F);
        inta_n = 1'b1; tick();

        // Non-specific EOI with rotate
        do_reset();
        eoi_level = 3'd2; set_priority_valid = 1'b1; tick();
        set_priority_valid = 1'b0; sample();
        check("t3_rot_set", {5'd0, priority_rotate}, 8'h03);
        ack(8'h04);
        ack(8'h20);
        sample();
        check("t3_isr", in_service_register, 8'h24);
        eoi_valid = 1'b1; eoi_specific = 1'b0; eoi_rotate = 1'b1;
        tick();
        eoi_valid = 1'b0; eoi_rotate = 1'b0; sample();
        check("t3_isr_after", in_service_register, 8'h04);
        check("t3_rot_after", {5'd0, priority_rotate}, 8'h06);

        // Auto-EOI with rotate, wrap of the pointer
        do_reset();
        eoi_level = 3'd4; set_priority_valid = 1'b1; tick();
        set_priority_valid = 1'b0;
        auto_eoi = 1'b1; auto_rotate = 1'b1;
        interrupt = 8'h80; tick();
        inta_n = 1'b0; tick();
        interrupt = '0; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick(); sample();
        check("t4_isr_mid", in_service_register, 8'h80);
        inta_n = 1'b1; tick(); sample();
        check("t4_isr_clear", in_service_register, 8'h00);
        check("t4_rot_wrap", {5'd0, priority_rotate}, 8'h00);
        auto_eoi = 1'b0; auto_rotate = 1'b0;

        // Set wins over a same-cycle specific EOI
        do_reset();
        interrupt = 8'h04; tick();
        inta_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        eoi_valid = 1'b0; eoi_specific = 1'b0; sample();
        check("t5_set_wins", in_service_register, 8'h04);
        interrupt = '0; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();

        // Asynchronous reset in ACK1
        do_reset();
        interrupt = 8'h02; tick();
        inta_n = 1'b0; tick();
        interrupt = '0; inta_n = 1'b1; tick(); sample();
        check("t6_isr_before", in_service_register, 8'h02);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_int", {7'd0, int_out}, 8'h00);
        check("t6_rst_isr", in_service_register, 8'h00);
        check("t6_rst_rot", {5'd0, priority_rotate}, 8'h00);
        check("t6_rst_clr", clear_request, 8'h00);
        check("t6_rst_dout", data_out, 8'h00);
        check("t6_rst_den", {7'd0, data_out_en}, 8'h00);
        @(negedge clk);
        #1 rst_n = 1'b1;
        inta_n = 1'b0; tick(); sample();
        check("t6_idle_fall_den", {7'd0, data_out_en}, 8'h00);
        check("t6_idle_fall_int", {7'd0, int_out}, 8'h00);
        inta_n = 1'b1; tick();

        // Randomised traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 9) == 0)
                interrupt = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'd1 << $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) inta_n = ~inta_n;
            eoi_valid = ($urandom_range(0, 9) == 0);
            eoi_specific = 1'($urandom_range(0, 1));
            eoi_rotate = 1'($urandom_range(0, 1));
            eoi_level = 3'($urandom_range(0, 7));
            set_priority_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                auto_eoi = 1'($urandom_range(0, 1));
                auto_rotate = 1'($urandom_range(0, 1));
                vector_base = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
